// File: rtl/idct_pkg.sv
// Shared constants for the 8-point inverse DCT row stage: the 8x8 basis
// table, rounding constant, shift and default lane widths.
// Optional feature macro used by the stage: IDCT_SAT_EN (clamp instead of wrap).
package idct_pkg;

  localparam int IDCT_IW_DEF = 32'sd12;  // input coefficient width
  localparam int IDCT_BW_DEF = 32'sd11;  // output sample width
  localparam int IDCT_CW     = 32'sd8;   // coefficient width (signed)
  localparam int IDCT_GUARD  = 32'sd3;   // growth of an 8-term sum
  localparam int IDCT_RND    = 32'sd64;  // half LSB of the result scale
  localparam int IDCT_SHIFT  = 32'sd7;   // basis scale is 2^7

  // C[k][n] = round(128 * a(k) * cos((2n+1) k pi / 16)); row k, column n.
  localparam logic signed [7:0] IDCT_C [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

  // Width of one full-precision product.
  function automatic int idct_prod_w(input int iw);
    return iw + IDCT_CW;
  endfunction

  // Width of the full-precision 8-term lane sum.
  function automatic int idct_acc_w(input int iw);
    return iw + IDCT_CW + IDCT_GUARD;
  endfunction

endpackage

// File: rtl/idct_mac8.sv
// One output lane of the IDCT row stage: 8 multiplies by this column's basis
// values, an adder tree, round-half-up by 2^7, then clamp or wrap to BW bits.
// Three register stages (products, sum, result) all advance on en_i.
// Macro IDCT_SAT_EN: when defined, clamp and report saturation; otherwise
// keep the low BW bits and report no saturation.
module idct_mac8
  import idct_pkg::*;
#(
  parameter int IW  = IDCT_IW_DEF,
  parameter int BW  = IDCT_BW_DEF,
  parameter int COL = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [8*IW-1:0] y_i,
  output logic [BW-1:0]   x_o,
  output logic            sat_o
);

  localparam int PW = idct_prod_w(IW);
  localparam int AW = idct_acc_w(IW);
  localparam int RW = AW - IDCT_SHIFT;

  logic signed [PW-1:0] prod_s [8];
  logic signed [PW-1:0] prod_q [8];
  logic signed [AW-1:0] sum_s;
  logic signed [AW-1:0] sum_q;
  logic signed [AW-1:0] sum_rnd_s;
  logic signed [RW-1:0] rnd_s;
  logic [BW-1:0]        x_s;
  logic                 sat_s;
  logic [BW-1:0]        x_q;
  logic                 sat_q;
  logic                 unused_bits_s;

  // Multiply every input coefficient by this column's basis value.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      prod_s[k] = PW'($signed(y_i[k*IW +: IW])) * PW'(IDCT_C[k][COL]);
    end
  end

  // S1: capture the eight products.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 8; k++) begin
        prod_q[k] <= '0;
      end
    end else if (en_i) begin
      for (int k = 0; k < 8; k++) begin
        prod_q[k] <= prod_s[k];
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        prod_q[k] <= prod_q[k];
      end
    end
  end

  // Sum the products at full precision (sign-extended, no loss).
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < 8; k++) begin
      sum_s = sum_s + AW'(prod_q[k]);
    end
  end

  // S2: capture the lane sum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_s;
    end else begin
      sum_q <= sum_q;
    end
  end

  // Round half up: add 64, then keep the bits above the 7-bit fraction.
  assign sum_rnd_s = sum_q + AW'(IDCT_RND);
  assign rnd_s     = $signed(sum_rnd_s[AW-1:IDCT_SHIFT]);

`ifdef IDCT_SAT_EN
  localparam int MAX_I = (32'sd1 <<< (BW - 1)) - 32'sd1;
  localparam int MIN_I = -(32'sd1 <<< (BW - 1));
  localparam logic signed [RW-1:0] MAX_R = RW'(MAX_I);
  localparam logic signed [RW-1:0] MIN_R = RW'(MIN_I);
  localparam logic [BW-1:0]        MAX_B = BW'(MAX_I);
  localparam logic [BW-1:0]        MIN_B = BW'(MIN_I);

  // Clamp the rounded value into the signed BW-bit range.
  always_comb begin
    x_s   = rnd_s[BW-1:0];
    sat_s = 1'b0;
    if (rnd_s > MAX_R) begin
      x_s   = MAX_B;
      sat_s = 1'b1;
    end else if (rnd_s < MIN_R) begin
      x_s   = MIN_B;
      sat_s = 1'b1;
    end else begin
      x_s   = rnd_s[BW-1:0];
      sat_s = 1'b0;
    end
  end
`else
  // Two's-complement wrap: keep only the low BW bits.
  always_comb begin
    x_s   = rnd_s[BW-1:0];
    sat_s = 1'b0;
  end
`endif

  // Fraction bits and the wrapped-away upper bits are intentionally dropped.
  assign unused_bits_s = ^{sum_rnd_s[IDCT_SHIFT-1:0], rnd_s};

  // S3: capture the final sample and its saturation bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      sat_q <= 1'b0;
    end else if (en_i) begin
      x_q   <= x_s;
      sat_q <= sat_s;
    end else begin
      x_q   <= x_q;
      sat_q <= sat_q;
    end
  end

  assign x_o   = x_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/idct_row_stage.sv
// 8-point inverse DCT on one row per cycle, 3-stage pipeline with a single
// global stall driven by output backpressure. Tracks row position within an
// 8x8 block (out_last) and counts completed blocks modulo 4096.
// Macro IDCT_SAT_EN: clamp lanes and report sat_flag; default build wraps.
module idct_row_stage
  import idct_pkg::*;
#(
  parameter int IW = IDCT_IW_DEF,
  parameter int BW = IDCT_BW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [8*IW-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [8*BW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [11:0]     block_cnt,
  output logic            sat_flag
);

  logic        adv_s;
  logic        acc_s;
  logic        xfer_s;
  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  logic        ov_q, ov_d;
  logic [2:0]  row_q, row_d;
  logic [11:0] blk_q, blk_d;
  logic [8*BW-1:0] lane_x_s;
  logic [7:0]      lane_sat_s;

  // The pipeline moves only when the output slot is empty or being taken.
  assign adv_s    = !ov_q || out_ready;
  assign in_ready = reset && adv_s;
  assign acc_s    = in_valid && in_ready;
  assign xfer_s   = ov_q && out_ready;

  // Stage valid bits shift together; a stall freezes all of them.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    ov_d = ov_q;
    if (adv_s) begin
      v1_d = acc_s;
      v2_d = v1_q;
      ov_d = v2_q;
    end else begin
      v1_d = v1_q;
      v2_d = v2_q;
      ov_d = ov_q;
    end
  end

  // Row and block counters step only on an output transfer.
  always_comb begin
    row_d = row_q;
    blk_d = blk_q;
    if (xfer_s) begin
      row_d = row_q + 3'd1;
      if (row_q == 3'd7) begin
        blk_d = blk_q + 12'd1;
      end else begin
        blk_d = blk_q;
      end
    end else begin
      row_d = row_q;
      blk_d = blk_q;
    end
  end

  // Valid pipeline and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ov_q  <= 1'b0;
      row_q <= 3'd0;
      blk_q <= 12'd0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      ov_q  <= ov_d;
      row_q <= row_d;
      blk_q <= blk_d;
    end
  end

  // One datapath lane per output sample, each with its own basis column.
  for (genvar n = 0; n < 8; n++) begin : g_lane
    idct_mac8 #(
      .IW  (IW),
      .BW  (BW),
      .COL (n)
    ) u_lane (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (adv_s),
      .y_i    (in_data),
      .x_o    (lane_x_s[n*BW +: BW]),
      .sat_o  (lane_sat_s[n])
    );
  end

  assign out_data  = lane_x_s;
  assign out_valid = ov_q;
  assign out_last  = ov_q && (row_q == 3'd7);
  assign block_cnt = blk_q;
  assign sat_flag  = ov_q && (|lane_sat_s);

endmodule

// File: tb/tb_idct_row_stage.sv
// Self-checking bench for idct_row_stage: a real-arithmetic IDCT model feeds
// a queue of expected rows; one compare process checks every output cycle.
module tb_idct_row_stage;

  localparam int IW = 12;
  localparam int BW = 11;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [8*IW-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*BW-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic [11:0]     block_cnt;
  logic            sat_flag;

  idct_row_stage #(.IW(IW), .BW(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .block_cnt (block_cnt),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*BW-1:0] d;
    logic            s;
    int              acc_cyc;
    bit              chk_lat;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ctab [8][8];
  exp_t exp_q [$];
  exp_t cmp_e;
  int   exp_row = 0;
  int   exp_blk = 0;
  int   xfer_n = 0;
  bit   stall_seen = 1'b0;
  bit   seen_4095 = 1'b0;
  bit   stall_prev = 1'b0;
  logic [8*BW-1:0] prev_data;
  logic            prev_last;
  logic            prev_sat;
  logic [8*BW-1:0] last_out = '0;
  logic            last_sat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [8*BW-1:0] act,
                           input logic [8*BW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int lane_of(input logic [8*BW-1:0] d, input int n);
    logic [BW-1:0] t;
    t = d[n*BW +: BW];
    return int'($signed(t));
  endfunction

  // Spec-level model: x[n] = sum_k C[k][n]*y[k], round half up by 2^7.
  function automatic void model(input int y[8], output logic [8*BW-1:0] d,
                                output logic s);
    int acc;
    int r;
    s = 1'b0;
    d = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) acc += ctab[k][n] * y[k];
      r = (acc + 64) >>> 7;
`ifdef IDCT_SAT_EN
      if (r > 1023) begin r = 1023; s = 1'b1; end
      else if (r < -1024) begin r = -1024; s = 1'b1; end
`endif
      d[n*BW +: BW] = r[BW-1:0];
    end
  endfunction

  task automatic send_row(input int y[8], input bit lat);
    logic [8*IW-1:0] p;
    exp_t e;
    int   tv;
    bit   ok;
    for (int k = 0; k < 8; k++) begin
      tv = y[k];
      p[k*IW +: IW] = tv[IW-1:0];
    end
    in_data  = p;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model(y, e.d, e.s);
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        exp_q.push_back(e);
        ok = 1'b1;
      end
    end
    check("send_accept", int'(ok), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check_vec("rst_out_data", out_data, '0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_block_cnt", int'(block_cnt), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    exp_q.delete();
    exp_row = 0;
    exp_blk = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Compare process: every cycle while out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready", int'(in_ready), int'(out_ready || !out_valid));
      check("block_cnt", int'(block_cnt), exp_blk);
      if (block_cnt == 12'd4095) seen_4095 = 1'b1;
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check_vec("hold_data", out_data, prev_data);
        check("hold_last", int'(out_last), int'(prev_last));
        check("hold_sat", int'(sat_flag), int'(prev_sat));
      end
      if (out_valid && !out_ready && !in_ready) stall_seen = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h expected no output", out_data);
        end else begin
          cmp_e = exp_q.pop_front();
          check_vec("out_data", out_data, cmp_e.d);
          check("sat_flag", int'(sat_flag), int'(cmp_e.s));
          check("out_last", int'(out_last), int'(exp_row == 7));
          if (cmp_e.chk_lat) check("latency", cyc - cmp_e.acc_cyc, 3);
          exp_row = (exp_row + 1) % 8;
          if (exp_row == 0) exp_blk = (exp_blk + 1) % 4096;
          xfer_n++;
          last_out = out_data;
          last_sat = sat_flag;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_sat   = sat_flag;
    end
  end

  initial begin
    int y[8];
    int ev[8];
    int lit0[8];
    int x0;
    logic [8*BW-1:0] md;
    logic ms;
    int xf0;
    real a;

    // Basis table straight from the cosine definition.
    for (int k = 0; k < 8; k++) begin
      a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
      for (int n = 0; n < 8; n++)
        ctab[k][n] = int'(128.0 * a * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0));
    end

    // Pin the model with hand-computed values.
    lit0 = '{45, 63, 59, 53, 45, 36, 24, 12};
    for (int k = 0; k < 8; k++) check("model_coef_col0", ctab[k][0], lit0[k]);
    y = '{64, 0, 0, 0, 0, 0, 0, 0};
    model(y, md, ms);
    for (int n = 0; n < 8; n++) check("model_dc", lane_of(md, n), 23);
    y = '{0, 64, 0, 0, 0, 0, 0, 0};
    ev = '{32, 27, 18, 6, -6, -18, -26, -31};
    model(y, md, ms);
    for (int n = 0; n < 8; n++) check("model_ac1", lane_of(md, n), ev[n]);
    y = '{100, 50, 0, 0, -30, 0, 0, 0};
    ev = '{49, 66, 60, 29, 20, 32, 25, 0};
    model(y, md, ms);
    for (int n = 0; n < 8; n++) check("model_mix", lane_of(md, n), ev[n]);

    // Reset state while reset is held low from time zero.
    #1;
    check("init_out_valid", int'(out_valid), 0);
    check("init_in_ready", int'(in_ready), 0);
    check("init_block_cnt", int'(block_cnt), 0);
    check_vec("init_out_data", out_data, '0);
    #11;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // DC only, with exact latency check.
    y = '{64, 0, 0, 0, 0, 0, 0, 0};
    send_row(y, 1'b1);
    drain();
    for (int n = 0; n < 8; n++) check("dut_dc", lane_of(last_out, n), 23);

    // Round-trip rows back to back.
    y = '{0, 64, 0, 0, 0, 0, 0, 0};
    send_row(y, 1'b0);
    y = '{-64, 0, 0, 0, 0, 0, 0, 0};
    send_row(y, 1'b0);
    y = '{100, 50, 0, 0, -30, 0, 0, 0};
    send_row(y, 1'b0);
    drain();
    ev = '{49, 66, 60, 29, 20, 32, 25, 0};
    for (int n = 0; n < 8; n++) check("dut_mix", lane_of(last_out, n), ev[n]);

    // Overflow: all coefficients at full scale.
    y = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    send_row(y, 1'b0);
    drain();
`ifdef IDCT_SAT_EN
    x0 = 1023;
    check("ovf_sat", int'(last_sat), 1);
`else
    x0 = -755;
    check("ovf_sat", int'(last_sat), 0);
`endif
    check("ovf_x0", lane_of(last_out, 0), x0);

    // Reset mid-stream with rows in flight.
    for (int i = 0; i < 4; i++) begin
      y = '{10 * i, 5, -3, 7, 0, 1, 2, 3};
      send_row(y, 1'b0);
    end
    do_reset();

    // Eight zero rows form block 0.
    y = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) send_row(y, 1'b0);
    drain();
    check_vec("zero_data", last_out, '0);
    check("zero_block_cnt", int'(block_cnt), 1);

    // Backpressure: output stalls during cycles 4-7 of a 10-row burst.
    xf0 = xfer_n;
    stall_seen = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          y = '{i * 50 - 200, i, -i, 3 * i, 0, -7, i * i, 100};
          send_row(y, 1'b0);
        end
      end
    join
    drain();
    check("bp_count", xfer_n - xf0, 10);
    check("bp_stall_seen", int'(stall_seen), 1);

    // Wrap: 32768 rows return block_cnt to 0.
    do_reset();
    xf0 = xfer_n;
    seen_4095 = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      for (int k = 0; k < 8; k++) y[k] = ((i * 37 + k * 101) % 4095) - 2047;
      send_row(y, 1'b0);
    end
    drain();
    check("wrap_count", xfer_n - xf0, 32768);
    check("wrap_seen_4095", int'(seen_4095), 1);
    check("wrap_block_cnt", int'(block_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idct_row_stage.md
IDCT_ROW_STAGE -- requirements
Module: idct_row_stage

Interface
REQ-001 SHALL have parameter IW, default 12: signed width of each input coefficient (matches the 2D-DCT output lane width).
REQ-002 SHALL have parameter BW, default 11: signed width of each output sample.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, 8*IW: coefficients y[0..7]; y[k] occupies bits [(k+1)*IW-1 : k*IW].
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: the block accepts in_data this cycle.
REQ-008 SHALL have port out_data, output, 8*BW: reconstructed samples x[0..7], using the same lane packing as in_data.
REQ-009 SHALL have port out_valid, output, 1: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1: the downstream consumer accepts out_data.
REQ-011 SHALL have port out_last, output, 1: qualified by out_valid; marks the 8th row of an 8x8 block.
REQ-012 SHALL have port block_cnt, output, 12: count of completed blocks, modulo 4096 (one 32768-word memory image).
REQ-013 SHALL have port sat_flag, output, 1: qualified by out_valid; at least one lane of out_data saturated.

Function
REQ-014 SHALL compute x[n] = sum over k of C[k][n]*y[k], where C[k][n] = round(128*a(k)*cos((2n+1)k*pi/16)), a(0)=sqrt(1/8), a(k>0)=1/2; C[k][0] = 45,63,59,53,45,36,24,12.
REQ-015 SHALL hold products and sums at full precision (IW+8+3 bits), then round: add 64, then arithmetic shift right by 7.
REQ-016 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-017 SHALL be a 3-stage pipeline: S1 registers the products, S2 registers the 8 lane sums, S3 registers the round/saturate result; an accepted input appears on out_data 3 cycles after acceptance when there is no stall.
REQ-018 SHALL hold every stage, with out_data/out_valid/out_last/sat_flag stable, while out_valid && !out_ready; in_ready SHALL be low during such a stall.
REQ-019 SHALL drive in_ready high whenever out_ready is high or out_valid is low; input data SHALL NOT be dropped or duplicated.
REQ-020 SHALL keep a 3-bit row counter that increments on each output transfer; out_last = (row==7); the counter wraps 7->0.
REQ-021 SHALL increment block_cnt on each output transfer with out_last=1, wrapping 4095->0.
REQ-022 SHALL propagate bubbles: an empty stage produces no out_valid, and the counters do not change.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear all stage valids, out_data, out_valid, out_last, sat_flag, the row counter and block_cnt to 0, and drive in_ready=0.
REQ-024 SHALL discard any data in flight when reset asserts mid-operation; after release, the first accepted row is row 0 of block 0.

Configuration
REQ-025 SHALL support macro IDCT_SAT_EN: when defined, clamp each lane to [-2^(BW-1), 2^(BW-1)-1] and set sat_flag when any lane clamps.
REQ-026 SHALL, without IDCT_SAT_EN, truncate each lane to its low BW bits (two's-complement wrap) and tie sat_flag to 0.

Structure
REQ-027 SHALL place the 8x8 coefficient table C, the rounding constant 64, the shift 7 and the default widths in shared package idct_pkg.
REQ-028 SHALL implement one output lane as sub-module idct_mac8 (8 multiplies, adder tree, round, saturate), instantiated 8 times with a column index parameter.

Verification
REQ-029 SHALL check DC only: y0=64, other lanes 0 -> all x[n]=23, exactly 3 cycles after acceptance.
REQ-030 SHALL check all-zero and reset: reset=0 mid-stream -> all outputs 0 immediately; then 8 zero rows -> out_data=0, out_last on the 8th, block_cnt=1.
REQ-031 SHALL check overflow: all y[k]=2047 -> x[0]=1023 with sat_flag=1 when IDCT_SAT_EN is defined; x[0]=-755 with sat_flag=0 when it is not.
REQ-032 SHALL check backpressure: 10 back-to-back rows with out_ready low for cycles 4-7 -> in_ready low during the stall, all 10 rows emitted in order, none lost.
REQ-033 SHALL check wrap: 32768 rows -> block_cnt returns to 0 and out_last asserts on every 8th transfer.
REQ-034 SHALL check round-trip: 2D-DCT output vectors fed row-wise -> results equal the golden inverse row vectors bit-exactly.
